// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   rx_state_t : receiver FSM states
//   PAR_*      : encodings of the PARITY parameter
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head word is visible on
// rdata_o whenever the FIFO is not empty, and it reads as zero when empty.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   push_i/wdata_i : write request and data. It is ignored when the FIFO is full
//                    and there is no pop.
//   pop_i          : remove the head word. It is ignored when the FIFO is empty.
//   rdata_o        : head word
//   count_o        : occupancy, 0..DEPTH
//   full_o/empty_o : occupancy flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_COUNT);
   assign do_pop  = pop_i && !empty_o;
   // When the FIFO is full, a simultaneous pop frees the slot that the write lands in.
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with a FWFT receive FIFO and CTS flow control.
//   clk_in, rst_n_in     : clock, asynchronous active-low reset
//   rx_in                : asynchronous serial line, idles high
//   data_out/valid_out   : FIFO head word and its not-empty flag
//   ready_in             : consumer accepts the head word
//   cts_n_out            : low while the sender may transmit
//   frame_err_out        : one-cycle pulse on a bad stop bit
//   parity_err_out       : one-cycle pulse on a parity mismatch
//   overflow_out         : one-cycle pulse when a good word is dropped because the FIFO is full
//   count_out            : FIFO occupancy
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a 1->0 edge
// ST_START  | checking the start bit at mid-bit
// ST_DATA   | shifting in DATA_BITS data bits, LSB first
// ST_PARITY | sampling the parity bit and latching the check result
// ST_STOP   | sampling the stop bit, then pushing or flagging the word
// ST_BREAK  | line held low after a framing error, waiting for idle
//
// The push and the error pulses are registered when the stop bit is sampled.
// They are high for the next cycle, and valid_out rises one cycle after the push.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int BAUD_COUNT = 645,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int DEPTH      = 16,
   parameter int CTS_MARGIN = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     rx_in,
   output logic [DATA_BITS-1:0]     data_out,
   output logic                     valid_out,
   input  logic                     ready_in,
   output logic                     cts_n_out,
   output logic                     frame_err_out,
   output logic                     parity_err_out,
   output logic                     overflow_out,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int CW = $clog2(BAUD_COUNT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_COUNT - 1);
   localparam logic [CW-1:0] CNT_MID   = CW'(BAUD_COUNT / 2);
   localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);
   localparam logic [AW:0]   CTS_LEVEL = (AW+1)'(DEPTH - CTS_MARGIN);
   localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

   logic                 sync1_q, rxs_q, rxs_prev_q;
   rx_state_t            state_q;
   logic [CW-1:0]        cnt_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bad_q;
   logic                 push_q, frame_err_q, parity_err_q;
   logic                 cts_n_q;
   logic                 fifo_empty, fifo_full, pop_ok;

   // The synchroniser resets to the idle level, so reset never creates a start edge.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync1_q    <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         sync1_q    <= rx_in;
         rxs_q      <= sync1_q;
         rxs_prev_q <= rxs_q;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         par_bad_q    <= 1'b0;
         push_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         push_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         cnt_q        <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         unique case (state_q)
            ST_IDLE: begin
               if (rxs_prev_q && !rxs_q) begin
                  state_q <= ST_START;
                  cnt_q   <= '0;
               end
            end
            ST_START: begin
               if (cnt_q == CNT_MID) begin
                  cnt_q     <= '0;
                  bit_q     <= '0;
                  par_bad_q <= 1'b0;
                  state_q   <= rxs_q ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == BITS_LAST)
                     state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (cnt_q == CNT_LAST) begin
                  par_bad_q <= ((^shift_q) ^ rxs_q) != ODD_PAR;
                  state_q   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (cnt_q == CNT_LAST) begin
                  if (!rxs_q) begin
                     // A framing error takes precedence over a parity failure.
                     frame_err_q <= 1'b1;
                     state_q     <= ST_BREAK;
                  end else if (par_bad_q) begin
                     parity_err_q <= 1'b1;
                     state_q      <= ST_IDLE;
                  end else begin
                     push_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_BREAK: begin
               if (rxs_q) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_in),
      .rst_n_i (rst_n_in),
      .push_i  (push_q),
      .wdata_i (shift_q),
      .pop_i   (ready_in),
      .rdata_o (data_out),
      .count_o (count_out),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign valid_out      = !fifo_empty;
   assign pop_ok         = valid_out && ready_in;
   assign overflow_out   = push_q && fifo_full && !pop_ok;
   assign frame_err_out  = frame_err_q;
   assign parity_err_out = parity_err_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) cts_n_q <= 1'b0;
      else           cts_n_q <= (count_out >= CTS_LEVEL);
   end

   assign cts_n_out = cts_n_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo. Two instances run from the same clock:
//   dut_a : 8N1, BAUD_COUNT=16, DEPTH=4, CTS_MARGIN=1
//   dut_b : 8E1, BAUD_COUNT=16, DEPTH=16, CTS_MARGIN=4
// Expected cycle offsets are counted from the cycle that drives the start edge:
// 2 synchroniser flops plus the edge register give START at +3, and the stop
// sample is registered at +156 (+172 with parity). valid_out follows one cycle later.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int BC = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_a, ready_a, valid_a, cts_a, ferr_a, perr_a, ovf_a;
   logic [7:0] data_a;
   logic [2:0] count_a;
   logic       rx_b, ready_b, valid_b, cts_b, ferr_b, perr_b, ovf_b;
   logic [7:0] data_b;
   logic [4:0] count_b;

   int cyc = 0;
   int pass_cnt = 0;
   int total = 0;
   int start_cyc = 0;

   logic [7:0] pop_a[$];
   logic [7:0] pop_b[$];
   int rise_a = -1, rise_b = -1, cts_rise_a = -1;
   int ferr_a_n = 0, perr_a_n = 0, ovf_a_n = 0, ferr_a_cyc = -1, ovf_a_cyc = -1;
   int ferr_b_n = 0, perr_b_n = 0, ovf_b_n = 0, perr_b_cyc = -1;
   logic valid_a_prev = 1'b0, valid_b_prev = 1'b0, cts_a_prev = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_fifo #(
      .BAUD_COUNT (BC), .DATA_BITS (8), .PARITY (0), .DEPTH (4), .CTS_MARGIN (1)
   ) dut_a (
      .clk_in (clk), .rst_n_in (rst_n), .rx_in (rx_a),
      .data_out (data_a), .valid_out (valid_a), .ready_in (ready_a),
      .cts_n_out (cts_a), .frame_err_out (ferr_a), .parity_err_out (perr_a),
      .overflow_out (ovf_a), .count_out (count_a)
   );

   uart_rx_fifo #(
      .BAUD_COUNT (BC), .DATA_BITS (8), .PARITY (1), .DEPTH (16), .CTS_MARGIN (4)
   ) dut_b (
      .clk_in (clk), .rst_n_in (rst_n), .rx_in (rx_b),
      .data_out (data_b), .valid_out (valid_b), .ready_in (ready_b),
      .cts_n_out (cts_b), .frame_err_out (ferr_b), .parity_err_out (perr_b),
      .overflow_out (ovf_b), .count_out (count_b)
   );

   // Observation at the falling edge: accepted words, rise cycles, pulse counts.
   always @(negedge clk) begin
      if (valid_a && ready_a) pop_a.push_back(data_a);
      if (valid_b && ready_b) pop_b.push_back(data_b);
      if (valid_a && !valid_a_prev) rise_a = cyc;
      if (valid_b && !valid_b_prev) rise_b = cyc;
      if (cts_a && !cts_a_prev) cts_rise_a = cyc;
      valid_a_prev = valid_a;
      valid_b_prev = valid_b;
      cts_a_prev   = cts_a;
      if (ferr_a) begin ferr_a_n++; ferr_a_cyc = cyc; end
      if (perr_a) perr_a_n++;
      if (ovf_a)  begin ovf_a_n++; ovf_a_cyc = cyc; end
      if (ferr_b) ferr_b_n++;
      if (perr_b) begin perr_b_n++; perr_b_cyc = cyc; end
      if (ovf_b)  ovf_b_n++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive_bit(input int sel, input logic b);
      if (sel == 0) rx_a = b;
      else          rx_b = b;
      repeat (BC) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                             input logic par_bit, input logic stop_bit);
      @(posedge clk);
      #1;
      start_cyc = cyc;
      drive_bit(sel, 1'b0);
      for (int k = 0; k < 8; k++) drive_bit(sel, d[k]);
      if (use_par) drive_bit(sel, par_bit);
      drive_bit(sel, stop_bit);
   endtask

   initial begin
      int s0, g;
      int sf[5];

      rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid_a", 32'(valid_a), 0);
      chk("rst_data_a",  32'(data_a), 0);
      chk("rst_cts_a",   32'(cts_a), 0);
      chk("rst_count_a", 32'(count_a), 0);
      chk("rst_errs_a",  32'({ferr_a, perr_a, ovf_a}), 0);
      chk("rst_valid_b", 32'(valid_b), 0);
      chk("rst_count_b", 32'(count_b), 0);
      chk("rst_state_a", 32'(dut_a.state_q), 32'(ST_IDLE));
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // Back-to-back 8N1 frames with the consumer always ready.
      ready_a = 1'b1;
      send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
      s0 = start_cyc;
      chk("a5_valid_rise", 32'(rise_a), 32'(s0 + 157));
      send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
      s0 = start_cyc;
      chk("3c_valid_rise", 32'(rise_a), 32'(s0 + 157));
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_pop_n",  32'(pop_a.size()), 2);
      chk("b2b_word0",  32'(pop_a[0]), 32'h0A5);
      chk("b2b_word1",  32'(pop_a[1]), 32'h03C);
      chk("b2b_noerr",  32'(ferr_a_n + perr_a_n + ovf_a_n), 0);
      chk("b2b_count",  32'(count_a), 0);

      // One-cycle low glitch: START is entered, then abandoned at mid-bit.
      @(posedge clk);
      #1;
      g = cyc;
      rx_a = 1'b0;
      @(posedge clk);
      #1;
      rx_a = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("glitch_start_at_mid", 32'(cyc), 32'(g + 11));
      chk("glitch_state_start", 32'(dut_a.state_q), 32'(ST_START));
      @(negedge clk);
      chk("glitch_state_idle", 32'(dut_a.state_q), 32'(ST_IDLE));
      repeat (20) @(posedge clk);
      #1;
      chk("glitch_no_push", 32'(pop_a.size()), 2);
      chk("glitch_no_err",  32'(ferr_a_n + perr_a_n), 0);

      // Bad stop bit followed by a held-low line.
      send_frame(0, 8'h55, 0, 1'b0, 1'b0);
      s0 = start_cyc;
      repeat (100) @(posedge clk);
      @(negedge clk);
      chk("ferr_count",   32'(ferr_a_n), 1);
      chk("ferr_cycle",   32'(ferr_a_cyc), 32'(s0 + 156));
      chk("ferr_state",   32'(dut_a.state_q), 32'(ST_BREAK));
      chk("ferr_no_push", 32'(pop_a.size()), 2);
      chk("ferr_count_a", 32'(count_a), 0);
      @(posedge clk);
      #1;
      rx_a = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("break_exit_idle", 32'(dut_a.state_q), 32'(ST_IDLE));
      send_frame(0, 8'h81, 0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("after_break_word", 32'(pop_a[2]), 32'h081);
      chk("after_break_ferr", 32'(ferr_a_n), 1);

      // Fill a 4-deep FIFO with the consumer stalled: CTS at 3, overflow on the 5th.
      ready_a = 1'b0;
      for (int f = 0; f < 5; f++) begin
         send_frame(0, 8'(17 * (f + 1)), 0, 1'b0, 1'b1);
         sf[f] = start_cyc;
         if (f == 1) chk("cts_low_at_2", 32'(cts_a), 0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("cts_rise_cycle", 32'(cts_rise_a), 32'(sf[2] + 158));
      chk("ovf_count",      32'(ovf_a_n), 1);
      chk("ovf_cycle",      32'(ovf_a_cyc), 32'(sf[4] + 156));
      chk("full_count",     32'(count_a), 4);
      chk("full_head",      32'(data_a), 32'h011);
      chk("full_cts",       32'(cts_a), 1);
      ready_a = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_n",     32'(pop_a.size()), 7);
      chk("drain_w0",    32'(pop_a[3]), 32'h011);
      chk("drain_w1",    32'(pop_a[4]), 32'h022);
      chk("drain_w2",    32'(pop_a[5]), 32'h033);
      chk("drain_w3",    32'(pop_a[6]), 32'h044);
      chk("drain_count", 32'(count_a), 0);
      chk("drain_cts",   32'(cts_a), 0);

      // Reset in the middle of DATA with two words queued.
      ready_a = 1'b0;
      send_frame(0, 8'h12, 0, 1'b0, 1'b1);
      send_frame(0, 8'h34, 0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_count", 32'(count_a), 2);
      @(posedge clk);
      #1;
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b0);
      chk("pre_rst_state", 32'(dut_a.state_q), 32'(ST_DATA));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(valid_a), 0);
      chk("mid_rst_data",  32'(data_a), 0);
      chk("mid_rst_count", 32'(count_a), 0);
      chk("mid_rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
      rx_a = 1'b1;
      #2;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      ready_a = 1'b1;
      send_frame(0, 8'h56, 0, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_n",    32'(pop_a.size()), 8);
      chk("post_rst_word", 32'(pop_a[7]), 32'h056);
      chk("post_rst_errs", 32'(ferr_a_n), 1);

      // Even parity on dut_b.
      ready_b = 1'b1;
      send_frame(1, 8'h07, 1, 1'b0, 1'b1);
      s0 = start_cyc;
      repeat (3) @(posedge clk);
      #1;
      chk("perr_count",   32'(perr_b_n), 1);
      chk("perr_cycle",   32'(perr_b_cyc), 32'(s0 + 172));
      chk("perr_no_push", 32'(pop_b.size()), 0);
      chk("perr_count_b", 32'(count_b), 0);
      send_frame(1, 8'h07, 1, 1'b1, 1'b1);
      s0 = start_cyc;
      chk("par_ok_rise",  32'(rise_b), 32'(s0 + 173));
      send_frame(1, 8'hA5, 1, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("par_ok_n",     32'(pop_b.size()), 2);
      chk("par_ok_word0", 32'(pop_b[0]), 32'h007);
      chk("par_ok_word1", 32'(pop_b[1]), 32'h0A5);
      chk("par_ok_perr",  32'(perr_b_n), 1);
      // Bad parity and bad stop together report only the framing error.
      send_frame(1, 8'h07, 1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("both_bad_ferr", 32'(ferr_b_n), 1);
      chk("both_bad_perr", 32'(perr_b_n), 1);
      chk("both_bad_n",    32'(pop_b.size()), 2);
      chk("b_no_ovf",      32'(ovf_b_n), 0);
      rx_b = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("b_state_idle",  32'(dut_b.state_q), 32'(ST_IDLE));

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with on-chip FIFO and hardware flow control, replacing the fixed 8N1 `uart_rx` on the BLE serial link. It turns the serial line into FIFO-buffered, ready/valid words for the gameplay logic, flags framing, parity and overflow errors, and throttles the BLE module through CTS. It sits in the pixel-clock domain beside `gameplay`.

## Interface
- `BAUD_COUNT`, 645: clock cycles per bit (74.25 MHz / 115200); at least 4.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `CTS_MARGIN`, 4: free entries remaining at which CTS deasserts; 1..DEPTH-1.

- `clk_in` input 1: pixel clock; sole clock.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `rx_in` input 1: asynchronous serial line; idles high.
- `data_out` output DATA_BITS: FIFO head word.
- `valid_out` output 1: FIFO not empty.
- `ready_in` input 1: consumer accepts the head word.
- `cts_n_out` output 1: low means the sender may transmit.
- `frame_err_out` output 1: one-cycle pulse on a bad stop bit.
- `parity_err_out` output 1: one-cycle pulse on a parity mismatch.
- `overflow_out` output 1: one-cycle pulse when a good word is dropped because the FIFO is full.
- `count_out` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- `rx_in` passes through a 2-flop synchroniser; both flops reset to 1. All line logic uses the synchronised `rxs`.
- The FSM has six states: IDLE, START, DATA, PARITY, STOP, BREAK. A bit counter counts 0..BAUD_COUNT-1.
- IDLE: a 1→0 edge on `rxs` moves to START and clears the counter.
- START: at count BAUD_COUNT/2 (integer division):
  - `rxs`=0: go to DATA and clear the counter.
  - `rxs`=1 (glitch): go to IDLE with no error.
- DATA: sample at each count of BAUD_COUNT-1 into a shift register, LSB first.
  - After DATA_BITS samples, go to PARITY if PARITY≠0, else STOP.
- PARITY: sample once and compare against the XOR of the data bits.
  - Even: the XOR of data and the parity bit must be 0. Odd: it must be 1.
  - The result is latched for STOP.
- STOP: sample once.
  - Stop bit 1 and parity good: push the word and go to IDLE.
  - Stop bit 1 and parity bad: pulse `parity_err_out`, discard the word, go to IDLE.
  - Stop bit 0: pulse `frame_err_out` only (even if parity also failed), discard the word, go to BREAK.
- BREAK: stay until `rxs`=1, then go to IDLE. This stops a held-low line from producing false starts.
- FIFO is first-word-fall-through.
  - `valid_out` = count≠0. `data_out` = head word when valid, else 0.
  - Pop when `valid_out && ready_in`. `ready_in` while empty has no effect.
  - Push when full without a pop: drop the word and pulse `overflow_out`.
  - Push and pop in the same cycle (full or not): both happen and count is unchanged.
  - Pointers wrap modulo DEPTH. Count saturates at 0 and DEPTH.
- Flow control: `cts_n_out` is registered from count and is 1 when count ≥ DEPTH-CTS_MARGIN, else 0.
- Reset (asynchronous, valid at any point, including mid-frame):
  - FSM to IDLE, pointers and count to 0, partial frame discarded.
  - `valid_out`=0, `data_out`=0, `cts_n_out`=0, all error pulses 0, `count_out`=0.

## Timing
- Rising edge of `clk_in` only.
- Input path: 2 cycles of synchroniser latency, then edge detection on `rxs`.
- Sample points after the START transition:
  - Start bit: BAUD_COUNT/2 cycles.
  - Data bit k: BAUD_COUNT/2 + (k+1)·BAUD_COUNT.
  - Parity and stop bits follow at the same BAUD_COUNT spacing.
- The push, and any error or overflow pulse, happens in the stop-sample cycle. `valid_out` rises the next cycle.
- Pop takes effect the cycle after the handshake. The next head word appears on `data_out` in that same cycle.
- `cts_n_out` follows count with 1 cycle of latency.
- Back-to-back frames: IDLE is re-entered at the stop sample, so a start edge half a bit later is caught.

## Structure
- Package `uart_pkg`: state enum `rx_state_t`, parity constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
- Sub-module `sync_fifo #(WIDTH, DEPTH)`: FWFT storage, pointers, count, full/empty. Reusable for a future TX path.
- Receiver FSM, synchroniser and CTS logic stay in `uart_rx_fifo`.

## Test plan
- 8N1, BAUD_COUNT=16, frames 0xA5 then 0x3C back-to-back, `ready_in`=1 → `data_out` shows 0xA5 then 0x3C, each `valid_out` rises 1 cycle after its stop sample, no error pulses.
- PARITY=1, frame 0x07 with parity bit 0 → `parity_err_out` pulses once, count stays 0. Repeat with parity bit 1 → word accepted.
- Stop bit forced 0, line then held low 100 cycles, then released → single `frame_err_out`, FSM in BREAK, no words pushed, next frame received normally.
- DEPTH=4, CTS_MARGIN=1, `ready_in`=0, send 5 frames → `cts_n_out` rises 1 cycle after the 3rd push, 5th word dropped with `overflow_out` pulse, drain yields the first 4 words in order.
- 1-cycle low glitch on `rx_in` → no push, no error, FSM back in IDLE at count BAUD_COUNT/2.
- Assert `rst_n_in` mid-DATA with 2 words queued → all outputs at reset values immediately, following frame received intact.
